// File: rtl/graph_query_sequencer.sv
// Query front-end for the graph shortest-path engine: owns the engine
// reset, steps it through forward/backward search and streams the edge chain.
module graph_query_sequencer #(
  parameter int MAX_LEVEL   = 10,
  parameter int NUM_POSE    = 66,
  parameter int TIMEOUT_CYC = 32768
) (
  input  logic                      CLK,
  input  logic                      RST_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [7:0]                req_start,
  input  logic [7:0]                req_end,
  input  logic                      abort,
  output logic                      busy,
  output logic                      graph_rst_n,
  output logic [2:0]                graph_control,
  output logic [7:0]                graph_startPose,
  output logic [7:0]                graph_endPose,
  input  logic [2:0]                graph_state,
  input  logic [3:0]                graph_maxLever,
  input  logic [MAX_LEVEL*11-1:0]   graph_selectEdge,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [10:0]               rsp_edge,
  output logic                      rsp_last,
  output logic [2:0]                rsp_status
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LIM  = TW'(TIMEOUT_CYC);
  localparam logic [7:0]    POSE_LIM = 8'(NUM_POSE);
  localparam logic [3:0]    LVL_LIM  = 4'(MAX_LEVEL);

  localparam logic [2:0] G_FWD_WORK = 3'd1;
  localparam logic [2:0] G_BWD_INIT = 3'd2;
  localparam logic [2:0] G_BWD_WORK = 3'd3;
  localparam logic [2:0] G_FAIL     = 3'd4;
  localparam logic [2:0] G_FINISH   = 3'd5;

  localparam logic [2:0] ST_OK      = 3'd0;
  localparam logic [2:0] ST_NO_PATH = 3'd1;
  localparam logic [2:0] ST_TIMEOUT = 3'd2;
  localparam logic [2:0] ST_BAD_REQ = 3'd3;
  localparam logic [2:0] ST_ABORT   = 3'd4;

  localparam logic [2:0] CTL_FWD = 3'b010;
  localparam logic [2:0] CTL_BWD = 3'b100;

  typedef enum logic [2:0] {
    IDLE, RESET, ARM, FWD, BARM, BWD, EMIT, REPORT
  } state_t;

  typedef logic [MAX_LEVEL-1:0][10:0] slots_t;

  state_t      state, stateN;
  logic        rstCnt, rstCntN;
  logic [TW-1:0] tmoCnt, tmoN, tmoInc;
  logic [3:0]  len, lenN, lenIn;
  logic [3:0]  idx, idxN, idxInc;
  slots_t      edges, edgesN;

  logic        reqRdyN, busyN, gRstN;
  logic [2:0]  ctrlN;
  logic [7:0]  startN, endN;
  logic        vN, lN;
  logic [10:0] eN;
  logic [2:0]  sN;

  logic        fire, done, active, abortable, badReq;

  assign fire   = rsp_valid & rsp_ready;
  assign active = state inside {ARM, FWD, BARM, BWD};
  assign abortable = active | (state == RESET);
  assign tmoInc = tmoCnt + 1'b1;
  assign idxInc = idx + 4'd1;
  assign lenIn  = (graph_maxLever > LVL_LIM) ? LVL_LIM : graph_maxLever;
  assign badReq = (req_start == req_end) ||
                  (req_start >= POSE_LIM) ||
                  (req_end >= POSE_LIM);

  always_comb begin
    stateN  = state;
    rstCntN = rstCnt;
    tmoN    = tmoCnt;
    lenN    = len;
    idxN    = idx;
    edgesN  = edges;
    reqRdyN = req_ready;
    busyN   = busy;
    gRstN   = graph_rst_n;
    ctrlN   = 3'b000;
    startN  = graph_startPose;
    endN    = graph_endPose;
    vN      = rsp_valid;
    eN      = rsp_edge;
    lN      = rsp_last;
    sN      = rsp_status;
    done    = 1'b0;

    if (active) tmoN = tmoInc;

    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          tmoN    = '0;
          busyN   = 1'b1;
          reqRdyN = 1'b0;
          if (badReq) begin
            stateN = REPORT;
            vN     = 1'b1;
            eN     = '0;
            lN     = 1'b1;
            sN     = ST_BAD_REQ;
          end else begin
            stateN  = RESET;
            rstCntN = 1'b0;
            startN  = req_start;
            endN    = req_end;
          end
        end
      end
      RESET: begin
        if (rstCnt) begin
          stateN = ARM;
          gRstN  = 1'b1;
        end else begin
          rstCntN = 1'b1;
        end
      end
      ARM: begin
        // first ARM cycle keeps control idle while edgeMask loads
        if (graph_control == CTL_FWD && graph_state == G_FWD_WORK)
          stateN = FWD;
        else
          ctrlN = CTL_FWD;
      end
      FWD: begin
        if (graph_state == G_BWD_INIT) begin
          stateN = BARM;
          ctrlN  = CTL_BWD;
        end else if (graph_state == G_FAIL) begin
          stateN = REPORT;
          vN     = 1'b1;
          eN     = '0;
          lN     = 1'b1;
          sN     = ST_NO_PATH;
        end
      end
      BARM: begin
        if (graph_state == G_BWD_WORK)
          stateN = BWD;
        else
          ctrlN = CTL_BWD;
      end
      BWD: begin
        if (graph_state == G_FINISH) begin
          stateN = EMIT;
          lenN   = lenIn;
          idxN   = '0;
          edgesN = graph_selectEdge;
          vN     = 1'b1;
          eN     = (lenIn == 4'd0) ? 11'd0 : graph_selectEdge[10:0];
          lN     = (lenIn <= 4'd1);
          sN     = ST_OK;
        end
      end
      EMIT: begin
        if (fire) begin
          if (rsp_last) begin
            done = 1'b1;
          end else begin
            idxN = idxInc;
            eN   = edges[idxInc];
            lN   = (idxInc + 4'd1 == len);
          end
        end
      end
      REPORT: begin
        if (fire) done = 1'b1;
      end
    endcase

    // abort outranks timeout, both outrank engine progress
    if (abortable && abort) begin
      stateN = REPORT;
      gRstN  = 1'b0;
      ctrlN  = 3'b000;
      vN     = 1'b1;
      eN     = '0;
      lN     = 1'b1;
      sN     = ST_ABORT;
    end else if (active && tmoInc == TMO_LIM) begin
      stateN = REPORT;
      gRstN  = 1'b0;
      ctrlN  = 3'b000;
      vN     = 1'b1;
      eN     = '0;
      lN     = 1'b1;
      sN     = ST_TIMEOUT;
    end

    if (done) begin
      stateN  = IDLE;
      busyN   = 1'b0;
      reqRdyN = 1'b1;
      gRstN   = 1'b0;
      startN  = '0;
      endN    = '0;
      vN      = 1'b0;
      eN      = '0;
      lN      = 1'b0;
      sN      = ST_OK;
    end

    if (stateN == IDLE) reqRdyN = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state           <= IDLE;
      rstCnt          <= 1'b0;
      tmoCnt          <= '0;
      len             <= '0;
      idx             <= '0;
      edges           <= '0;
      req_ready       <= 1'b0;
      busy            <= 1'b0;
      graph_rst_n     <= 1'b0;
      graph_control   <= 3'b000;
      graph_startPose <= '0;
      graph_endPose   <= '0;
      rsp_valid       <= 1'b0;
      rsp_edge        <= '0;
      rsp_last        <= 1'b0;
      rsp_status      <= ST_OK;
    end else begin
      state           <= stateN;
      rstCnt          <= rstCntN;
      tmoCnt          <= tmoN;
      len             <= lenN;
      idx             <= idxN;
      edges           <= edgesN;
      req_ready       <= reqRdyN;
      busy            <= busyN;
      graph_rst_n     <= gRstN;
      graph_control   <= ctrlN;
      graph_startPose <= startN;
      graph_endPose   <= endN;
      rsp_valid       <= vN;
      rsp_edge        <= eN;
      rsp_last        <= lN;
      rsp_status      <= sN;
    end
  end

endmodule

// File: tb/tb_graph_query_sequencer.sv
// Directed bench for graph_query_sequencer with a small behavioural
// engine stub that advances graph_state on the falling clock edge.
module tb_graph_query_sequencer;

  logic         CLK;
  logic         RST_n;
  logic         req_valid;
  logic         req_ready;
  logic [7:0]   req_start;
  logic [7:0]   req_end;
  logic         abort;
  logic         busy;
  logic         graph_rst_n;
  logic [2:0]   graph_control;
  logic [7:0]   graph_startPose;
  logic [7:0]   graph_endPose;
  logic [2:0]   graph_state;
  logic [3:0]   graph_maxLever;
  logic [109:0] graph_selectEdge;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [10:0]  rsp_edge;
  logic         rsp_last;
  logic [2:0]   rsp_status;

  int nChecks = 0;
  int nErrors = 0;

  graph_query_sequencer #(
    .MAX_LEVEL(10),
    .NUM_POSE(66),
    .TIMEOUT_CYC(100)
  ) dut (
    .CLK(CLK),
    .RST_n(RST_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_start(req_start),
    .req_end(req_end),
    .abort(abort),
    .busy(busy),
    .graph_rst_n(graph_rst_n),
    .graph_control(graph_control),
    .graph_startPose(graph_startPose),
    .graph_endPose(graph_endPose),
    .graph_state(graph_state),
    .graph_maxLever(graph_maxLever),
    .graph_selectEdge(graph_selectEdge),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_edge(rsp_edge),
    .rsp_last(rsp_last),
    .rsp_status(rsp_status)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // engine stub
  logic stuck = 1'b0;
  logic noPath = 1'b0;
  int   eCnt = 0;
  initial graph_state = 3'd0;

  always @(negedge CLK) begin
    if (!graph_rst_n) begin
      graph_state <= 3'd0;
      eCnt <= 0;
    end else begin
      case (graph_state)
        3'd0: if (graph_control == 3'b010) begin
          graph_state <= 3'd1;
          eCnt <= 0;
        end
        3'd1: if (!stuck) begin
          eCnt <= eCnt + 1;
          if (eCnt == 2) graph_state <= noPath ? 3'd4 : 3'd2;
        end
        3'd2: if (graph_control == 3'b100) begin
          graph_state <= 3'd3;
          eCnt <= 0;
        end
        3'd3: begin
          eCnt <= eCnt + 1;
          if (eCnt == 2) graph_state <= 3'd5;
        end
        default: ;
      endcase
    end
  end

  int cnt010 = 0;
  int cnt100 = 0;
  int cntRstHi = 0;
  always @(posedge CLK) begin
    if (graph_control == 3'b010) cnt010 <= cnt010 + 1;
    if (graph_control == 3'b100) cnt100 <= cnt100 + 1;
    if (graph_rst_n) cntRstHi <= cntRstHi + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sendReq(input logic [7:0] s, input logic [7:0] e);
    int k;
    k = 0;
    while (!req_ready && k < 50) begin
      tick();
      k++;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    req_start = s;
    req_end   = e;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic getBeat(output logic [10:0] e, output logic l,
                         output logic [2:0] s);
    int k;
    k = 0;
    while (!rsp_valid && k < 300) begin
      tick();
      k++;
    end
    check("beat_wait", 32'(rsp_valid), 32'd1);
    e = rsp_edge;
    l = rsp_last;
    s = rsp_status;
    tick();
  endtask

  task automatic pathQuery(input logic [3:0] lev, input logic [109:0] sel,
                           input logic [7:0] s, input bit timing);
    int n, nb, s010, s100;
    logic [10:0] e, exp;
    logic l;
    logic [2:0] st;
    graph_maxLever   = lev;
    graph_selectEdge = sel;
    n  = (lev > 4'd10) ? 10 : int'(lev);
    nb = (n == 0) ? 1 : n;
    s010 = cnt010;
    s100 = cnt100;
    sendReq(s, 8'd5);
    check("start_pose", 32'(graph_startPose), 32'(s));
    check("end_pose", 32'(graph_endPose), 32'd5);
    if (timing) begin
      check("t1_rst", 32'(graph_rst_n), 32'd0);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_ready", 32'(req_ready), 32'd0);
      tick();
      check("t2_rst", 32'(graph_rst_n), 32'd0);
      tick();
      check("t3_rst", 32'(graph_rst_n), 32'd1);
      check("t3_ctrl", 32'(graph_control), 32'd0);
      tick();
      check("t4_ctrl", 32'(graph_control), 32'd2);
    end
    for (int i = 0; i < nb; i++) begin
      getBeat(e, l, st);
      exp = (n == 0) ? 11'd0 : sel[i*11 +: 11];
      check("edge", 32'(e), 32'(exp));
      check("last", 32'(l), 32'(i == nb - 1));
      check("status", 32'(st), 32'd0);
    end
    check("saw_ctrl_fwd", 32'(cnt010 != s010), 32'd1);
    check("saw_ctrl_bwd", 32'(cnt100 != s100), 32'd1);
    check("ready_after", 32'(req_ready), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
    check("parked", 32'(graph_rst_n), 32'd0);
  endtask

  task automatic badQuery(input logic [7:0] s, input logic [7:0] e);
    int snap;
    snap = cntRstHi;
    sendReq(s, e);
    check("bad_valid", 32'(rsp_valid), 32'd1);
    check("bad_status", 32'(rsp_status), 32'd3);
    check("bad_last", 32'(rsp_last), 32'd1);
    check("bad_edge", 32'(rsp_edge), 32'd0);
    tick();
    check("bad_ready_after", 32'(req_ready), 32'd1);
    check("bad_rst_held", 32'(cntRstHi - snap), 32'd0);
  endtask

  logic [109:0] sel;
  logic [10:0]  e;
  logic         l;
  logic [2:0]   st;
  int           k;

  initial begin
    RST_n = 1'b0;
    req_valid = 1'b0;
    req_start = '0;
    req_end = '0;
    abort = 1'b0;
    rsp_ready = 1'b1;
    graph_maxLever = '0;
    graph_selectEdge = '0;
    repeat (3) tick();
    check("rst_graph_rst_n", 32'(graph_rst_n), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_ctrl", 32'(graph_control), 32'd0);
    RST_n = 1'b1;
    tick();
    check("first_ready", 32'(req_ready), 32'd1);

    // 3-edge path with extra junk slot beyond len
    sel = '0;
    sel[10:0]  = 11'd17;
    sel[21:11] = 11'd300;
    sel[32:22] = 11'd2047;
    sel[43:33] = 11'd5;
    pathQuery(4'd3, sel, 8'd0, 1'b1);

    // boundary pose 65 is legal; len 0 and clamped len 15
    pathQuery(4'd0, sel, 8'd65, 1'b0);
    for (int i = 0; i < 10; i++) sel[i*11 +: 11] = 11'(i * 100 + 7);
    pathQuery(4'd15, sel, 8'd1, 1'b0);

    // no path
    noPath = 1'b1;
    sendReq(8'd0, 8'd5);
    getBeat(e, l, st);
    check("nopath_status", 32'(st), 32'd1);
    check("nopath_last", 32'(l), 32'd1);
    check("nopath_edge", 32'(e), 32'd0);
    check("nopath_ready", 32'(req_ready), 32'd1);
    noPath = 1'b0;

    badQuery(8'd7, 8'd7);
    badQuery(8'd7, 8'd70);
    badQuery(8'd66, 8'd3);

    // timeout: engine stuck in FORWARD_WORK
    stuck = 1'b1;
    sendReq(8'd1, 8'd2);
    k = 1;
    while (!rsp_valid && k < 300) begin
      tick();
      k++;
    end
    check("tmo_latency", 32'(k), 32'd103);
    check("tmo_status", 32'(rsp_status), 32'd2);
    check("tmo_rst", 32'(graph_rst_n), 32'd0);
    tick();
    stuck = 1'b0;

    // abort during backward search
    graph_maxLever = 4'd2;
    sendReq(8'd0, 8'd5);
    k = 0;
    while (graph_control != 3'b100 && k < 50) begin
      tick();
      k++;
    end
    check("abort_reach_barm", 32'(graph_control), 32'd4);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_rst", 32'(graph_rst_n), 32'd0);
    check("abort_valid", 32'(rsp_valid), 32'd1);
    check("abort_status", 32'(rsp_status), 32'd4);
    check("abort_last", 32'(rsp_last), 32'd1);
    tick();
    sel = '0;
    sel[10:0]  = 11'd9;
    sel[21:11] = 11'd8;
    pathQuery(4'd2, sel, 8'd3, 1'b0);

    // backpressure mid-stream
    sel = '0;
    for (int i = 0; i < 4; i++) sel[i*11 +: 11] = 11'((i + 1) * 100);
    graph_maxLever = 4'd4;
    graph_selectEdge = sel;
    rsp_ready = 1'b0;
    sendReq(8'd2, 8'd5);
    k = 0;
    while (!rsp_valid && k < 300) begin
      tick();
      k++;
    end
    check("bp_first", 32'(rsp_edge), 32'd100);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_edge", 32'(rsp_edge), 32'd200);
      check("bp_hold_last", 32'(rsp_last), 32'd0);
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
    end
    rsp_ready = 1'b1;
    getBeat(e, l, st);
    check("bp_b1", 32'(e), 32'd200);
    getBeat(e, l, st);
    check("bp_b2", 32'(e), 32'd300);
    check("bp_b2_last", 32'(l), 32'd0);
    getBeat(e, l, st);
    check("bp_b3", 32'(e), 32'd400);
    check("bp_b3_last", 32'(l), 32'd1);
    check("bp_ready", 32'(req_ready), 32'd1);

    // reset while streaming
    rsp_ready = 1'b0;
    sendReq(8'd2, 8'd5);
    k = 0;
    while (!rsp_valid && k < 300) begin
      tick();
      k++;
    end
    check("emit_reached", 32'(rsp_valid), 32'd1);
    RST_n = 1'b0;
    tick();
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_edge", 32'(rsp_edge), 32'd0);
    check("mid_rst_last", 32'(rsp_last), 32'd0);
    check("mid_rst_graph", 32'(graph_rst_n), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_pose", 32'(graph_startPose), 32'd0);
    RST_n = 1'b1;
    rsp_ready = 1'b1;
    tick();
    check("post_rst_ready", 32'(req_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/graph_query_sequencer.md
# graph_query_sequencer

Front-end controller for the `graph` shortest-path engine. It accepts path queries (start pose, end pose) over a valid/ready handshake and drives the engine through reset, forward search and backward search. It watches the engine for failure or timeout and then streams the resulting edge chain, one edge index per beat, with a status code. The engine leaves FAIL/FINISH only through reset, so this block owns the engine's reset line and re-arms the engine for every query.

## Interface
- `MAX_LEVEL`, 10: number of `selectEdge` slots (11 bits each) in the engine.
- `NUM_POSE`, 66: pose count; a query pose must be below this value to be valid.
- `TIMEOUT_CYC`, 32768: cycle budget per query, from the first cycle of ARM until FINISH or FAIL.

- `CLK` in 1: clock; the engine shares it.
- `RST_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1, `req_ready` out 1: query handshake.
- `req_start` in 8, `req_end` in 8: query poses.
- `abort` in 1: single-cycle pulse that cancels the query in progress.
- `busy` out 1: high from query accept until the last response beat is accepted.
- `graph_rst_n` out 1: engine reset (active-low).
- `graph_control` out 3: engine `control`.
- `graph_startPose` out 8, `graph_endPose` out 8: engine pose inputs.
- `graph_state` in 3: engine `state`. Encoding: 0 FORWARD_INIT, 1 FORWARD_WORK, 2 BACKWARD_INIT, 3 BACKWARD_WORK, 4 FAIL, 5 FINISH.
- `graph_maxLever` in 4: engine level-count tap; number of valid `selectEdge` slots at FINISH.
- `graph_selectEdge` in 110: engine `selectEdge`.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_edge` out 11: edge index carried by the beat.
- `rsp_last` out 1: final beat of the response.
- `rsp_status` out 3: 0 OK, 1 NO_PATH, 2 TIMEOUT, 3 BAD_REQ, 4 ABORT.

## Operation
- All outputs are registered.
- Reset values:
  - `graph_rst_n`=0, so the engine is held in reset.
  - `graph_control`=0, poses=0.
  - `req_ready`=0, `busy`=0.
  - `rsp_valid`=0, `rsp_edge`=0, `rsp_last`=0, `rsp_status`=0.
- On the first cycle after reset: state IDLE, `req_ready`=1.
- States and transitions:
  - IDLE: `req_ready`=1. Accept on `req_valid`&`req_ready`. Latch the poses, clear the timeout counter, set `busy`.
    - If `req_start`==`req_end`, or either pose ≥ `NUM_POSE`: go to REPORT with BAD_REQ. The engine is not touched.
    - Otherwise go to RESET.
  - RESET: `graph_rst_n`=0 for exactly 2 cycles, so both engine clock edges see reset. Poses are driven onto `graph_startPose`/`graph_endPose` from this state onward and held until IDLE. Then go to ARM.
  - ARM: `graph_rst_n`=1. Wait one cycle with `graph_control`=0 while the engine loads edgeMask. Then drive `graph_control`=3'b010 until `graph_state`==1, then go to FWD.
  - FWD: `graph_control`=0.
    - `graph_state`==2 → BARM.
    - `graph_state`==4 → REPORT with NO_PATH.
  - BARM: `graph_control`=3'b100 until `graph_state`==3, then go to BWD.
  - BWD: `graph_control`=0. On `graph_state`==5, capture `graph_maxLever` as `len` and the 110-bit `graph_selectEdge`, then go to EMIT.
  - EMIT: one beat per slot i=0..len-1.
    - Beat contents: `rsp_edge`=slot i, `rsp_status`=OK, `rsp_last`=(i==len-1).
    - If `len`==0, emit a single beat: edge 0, OK, last.
    - `len` values above `MAX_LEVEL` are clamped to `MAX_LEVEL`.
  - REPORT: a single beat with edge 0, `rsp_last`=1, and the stored status.
- After the last beat is accepted: `busy`=0, `graph_rst_n` driven 0 (engine parked), return to IDLE.
- Timeout: the counter runs in ARM, FWD, BARM and BWD. When it reaches `TIMEOUT_CYC`, go to REPORT with TIMEOUT. This takes priority over a same-cycle `graph_state` transition.
- Abort: honoured in RESET, ARM, FWD, BARM and BWD. Go to REPORT with ABORT and drive `graph_rst_n`=0 at once. Abort is ignored in IDLE, EMIT and REPORT. Abort beats timeout when both occur in the same cycle.
- Slot order is the engine's: slot 0 is the edge incident to the end pose. The sequencer does not reorder.

## Timing
- Accept in cycle t. Then:
  - `graph_rst_n` is low in cycles t+1 and t+2.
  - `graph_control`=3'b010 is first driven in t+4.
- A BAD_REQ response is valid in cycle t+1.
- A response beat is held stable while `rsp_valid`&!`rsp_ready`. The next beat follows in the cycle after acceptance, so back-to-back throughput is 1 beat/cycle.
- `req_ready` is 0 from t+1 until the cycle after the last response beat is accepted. Only one query is in flight.
- `graph_state` changes on the engine's negedge. The sequencer samples it on posedge, so every `graph_state` decision carries 1 cycle of latency.
- FINISH to first `rsp_valid`: 1 cycle.

## Test plan
- Path search: reset, then query start=0, end=5 on a graph whose shortest path is 3 edges. Expected: control 3'b010 then 3'b100; 3 beats, slot0..slot2 indices, last on beat 3, status 0.
- No path: query with end=5 isolated by edgeMask. Expected: engine reaches FAIL; one beat, status 1, last=1; `req_ready` back to 1.
- Bad request: req_start=req_end=7, then separately req_end=70. Expected: one beat, status 3, in cycle t+1; `graph_rst_n` never released.
- Timeout: `TIMEOUT_CYC`=100 with the engine stubbed stuck in state 1. Expected: status 2 after exactly 100 counted cycles; `graph_rst_n`=0.
- Abort: pulse `abort` during BWD. Expected: `graph_rst_n` low the next cycle; one beat with status 4. A new query is then accepted and completes OK.
- Backpressure: hold `rsp_ready`=0 for 5 cycles mid-stream. Expected: `rsp_edge`/`rsp_last` stable; no beat lost or duplicated. Also assert `RST_n` during EMIT: all outputs return to their reset values the next cycle.
